tribus_arbiter: RTL and testbench
=================================

// Module: tribus_arbiter
// PURPOSE
//  Round-robin owner arbiter for a shared tristate net driven by N tristate
//  inverter drivers (one EN per driver, ZN = ~I while EN high, Z otherwise).
//  Grants bus ownership to one requester at a time. Guarantees break-before-make:
//  an all-EN-low gap of DEAD cycles between owners. Drives a keeper enable
//  while the net is undriven. Sits between bus clients and the invz driver array.
// PARAMETERS
//  N        4   number of requesters/drivers, 2..16
//  DEAD     1   turnaround cycles with all EN low between owners, 1..15
//  MAXHOLD  16  max DRIVE cycles while another requester waits; 0 = unlimited
// PORTS
//  CLK   in   1          clock, rising edge
//  RN    in   1          reset, asynchronous, active-low
//  REQ   in   N          per-driver bus request, level
//  EN    out  N          per-driver tristate enable, registered, one-hot or zero
//  GID   out  clog2(N)   index of current/last owner, registered
//  BUSY  out  1          1 while a driver owns the net (state DRIVE)
//  KEEP  out  1          bus-keeper enable, equal to ~BUSY, registered
// BEHAVIOUR
//  Reset (RN=0, takes effect immediately): EN=0, GID=0, BUSY=0, KEEP=1, state IDLE,
//   rr pointer=0, hold/dead counters=0. RN release is synchronised upstream.
//  States: IDLE, DRIVE, TURN.
//  IDLE: if |REQ, winner = first set REQ bit scanning up from pointer, mod N.
//   Next edge: DRIVE, EN=onehot(winner), GID=winner, BUSY=1, KEEP=0.
//   Latency REQ->EN is 1 cycle.
//  DRIVE: hold counter increments each cycle, saturating at MAXHOLD.
//   Release when REQ[GID]=0, or when MAXHOLD!=0, hold count = MAXHOLD-1 and
//   another REQ bit is set. The hold limit is never enforced with no other
//   requester. On release, next edge: EN=0, BUSY=0, KEEP=1, pointer=GID+1 mod N,
//   dead counter=DEAD-1, state TURN. GID holds its value.
//  TURN: EN stays 0 for exactly DEAD cycles. REQ changes during TURN are ignored
//   until the last TURN cycle. On that cycle REQ is sampled: if |REQ, arbitrate
//   as in IDLE and enter DRIVE on the next edge; otherwise enter IDLE.
//  A released owner that still requests re-competes at lowest priority.
//  Invariants: EN is onehot0 every cycle. EN never switches owner without an
//   intervening run of >=DEAD all-zero cycles. BUSY = |EN. KEEP = ~BUSY.
//  Reset mid-DRIVE: EN drops asynchronously; no DEAD gap is required after reset.
//  REQ bits for absent drivers (X) are not legal. The bench holds REQ known after reset.
// STRUCTURE
//  Package tribus_pkg holds:
//   - typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_TURN} tribus_state_t
//   - function/localparam for the GID width, clog2(N) with a minimum of 1
//   - localparam widths for the hold counter (clog2(MAXHOLD+1)) and the dead counter (4 bits)
//  Sub-module tribus_rr_pick: combinational round-robin picker
//   (req[N], ptr -> valid, idx), instantiated once.
//  Top level: state register, counters, pointer, and registered EN/GID/BUSY/KEEP.
// TESTING
//  1 Reset: in DRIVE with EN=0010, pull RN low -> EN=0, KEEP=1 within the same cycle.
//    Release RN -> IDLE, GID=0.
//  2 Single requester, DEAD=2: REQ=0010 at cycle 0 -> EN=0010, GID=1, BUSY=1 from
//    cycle 1. Drop REQ at cycle 5 -> EN=0 at cycle 6, EN=0 at cycle 7, IDLE at cycle 8.
//  3 Fairness, MAXHOLD=4, DEAD=1, REQ=1111 held -> owners 0,1,2,3,0 in order.
//    Each owner: EN high 4 cycles, then 1 all-zero cycle.
//  4 Lone holder, MAXHOLD=4: REQ=0100 held 40 cycles -> EN=0100 continuous,
//    never released.
//  5 Request in TURN: owner 0 drops REQ; REQ[3] rises in the first TURN cycle
//    (DEAD=3) -> EN=1000 exactly 3 zero cycles after EN[0] fell.
//  6 Random REQ, 10k cycles, N=5, DEAD=2, MAXHOLD=3 -> assertions hold:
//    onehot0(EN); gap >= DEAD between owners; KEEP == ~|EN; no starvation > N*(MAXHOLD+DEAD) cycles.

Source files
------------

// File: rtl/tribus_pkg.sv
// Shared types and width helpers for the tristate bus owner arbiter.
package tribus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } tribus_state_t;

  localparam int DEAD_W = 4;

  // Owner index width; a two-driver bus still needs one bit.
  function automatic int gid_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Hold counter counts 0..MAXHOLD; MAXHOLD=0 still gets a one-bit counter.
  function automatic int hold_width(input int maxhold);
    return ($clog2(maxhold + 1) < 1) ? 1 : $clog2(maxhold + 1);
  endfunction

endpackage

// File: rtl/tribus_rr_pick.sv
// Combinational round-robin picker: first set request scanning up from ptr_i, mod N.
module tribus_rr_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] ptr_i,
  output logic          valid_o,
  output logic [GW-1:0] idx_o
);

  logic [GW-1:0] cand [N];
  logic [N-1:0]  hit;

  // cand[k] is the driver index k places after the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [GW:0] sum;
    assign sum       = {1'b0, ptr_i} + (GW+1)'(gi);
    assign cand[gi]  = (sum >= (GW+1)'(N)) ? GW'(sum - (GW+1)'(N)) : GW'(sum);
    assign hit[gi]   = req_i[cand[gi]];
  end

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        valid_o = 1'b1;
        idx_o   = cand[k];
      end
    end
  end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner arbiter for a shared tristate net with break-before-make
// turnaround and a bus-keeper enable while nobody drives.
module tribus_arbiter
  import tribus_pkg::*;
#(
  parameter int N       = 4,
  parameter int DEAD    = 1,
  parameter int MAXHOLD = 16,
  localparam int GW     = gid_width(N),
  localparam int HW     = hold_width(MAXHOLD)
) (
  input  logic          clk_i,
  input  logic          rn_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  en_o,
  output logic [GW-1:0] gid_o,
  output logic          busy_o,
  output logic          keep_o
);

  tribus_state_t     state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic [N-1:0]      en_q, en_d;
  logic [GW-1:0]     gid_q, gid_d;
  logic              busy_q, busy_d;
  logic              keep_q, keep_d;

  logic              pick_valid;
  logic [GW-1:0]     pick_idx;
  logic              grant;
  logic              owner_req;
  logic              others_req;
  logic              hold_limit;

  tribus_rr_pick #(.N(N), .GW(GW)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign owner_req  = req_i[gid_q];
  assign others_req = |(req_i & ~en_q);
  // >= rather than == so a requester arriving after saturation still preempts.
  assign hold_limit = (MAXHOLD != 0) && (int'(hold_q) >= MAXHOLD - 1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    en_d    = en_q;
    gid_d   = gid_q;
    busy_d  = busy_q;
    keep_d  = keep_q;
    grant   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant = pick_valid;
      end
      ST_DRIVE: begin
        if (int'(hold_q) < MAXHOLD) hold_d = hold_q + HW'(1);
        if (!owner_req || (hold_limit && others_req)) begin
          state_d = ST_TURN;
          en_d    = '0;
          busy_d  = 1'b0;
          keep_d  = 1'b1;
          ptr_d   = (gid_q == GW'(N - 1)) ? '0 : gid_q + GW'(1);
          dead_d  = DEAD_W'(DEAD - 1);
        end
      end
      ST_TURN: begin
        if (dead_q == '0) begin
          grant = pick_valid;
          if (!pick_valid) state_d = ST_IDLE;
        end else begin
          dead_d = dead_q - DEAD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = '0;
        busy_d  = 1'b0;
        keep_d  = 1'b1;
      end
    endcase

    if (grant) begin
      state_d          = ST_DRIVE;
      en_d             = '0;
      en_d[pick_idx]   = 1'b1;
      gid_d            = pick_idx;
      busy_d           = 1'b1;
      keep_d           = 1'b0;
      hold_d           = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rn_i) begin
    if (!rn_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      dead_q  <= '0;
      en_q    <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      keep_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      en_q    <= en_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      keep_q  <= keep_d;
    end
  end

  assign en_o   = en_q;
  assign gid_o  = gid_q;
  assign busy_o = busy_q;
  assign keep_o = keep_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter across four parameter sets, plus a random invariant run.
module tb_tribus_arbiter;
  import tribus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn;
  logic [3:0] req_a, en_a, req_b, en_b, req_c, en_c;
  logic [1:0] gid_a, gid_b, gid_c;
  logic       busy_a, keep_a, busy_b, keep_b, busy_c, keep_c;
  logic [4:0] req_r, en_r;
  logic [2:0] gid_r;
  logic       busy_r, keep_r;

  int tests = 0;
  int fails = 0;

  tribus_arbiter #(.N(4), .DEAD(2), .MAXHOLD(16)) u_a (
    .clk_i(clk), .rn_i(rn), .req_i(req_a), .en_o(en_a), .gid_o(gid_a), .busy_o(busy_a), .keep_o(keep_a));
  tribus_arbiter #(.N(4), .DEAD(1), .MAXHOLD(4)) u_b (
    .clk_i(clk), .rn_i(rn), .req_i(req_b), .en_o(en_b), .gid_o(gid_b), .busy_o(busy_b), .keep_o(keep_b));
  tribus_arbiter #(.N(4), .DEAD(3), .MAXHOLD(16)) u_c (
    .clk_i(clk), .rn_i(rn), .req_i(req_c), .en_o(en_c), .gid_o(gid_c), .busy_o(busy_c), .keep_o(keep_c));
  tribus_arbiter #(.N(5), .DEAD(2), .MAXHOLD(3)) u_r (
    .clk_i(clk), .rn_i(rn), .req_i(req_r), .en_o(en_r), .gid_o(gid_r), .busy_o(busy_r), .keep_o(keep_r));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         zrun;
  int         waitc [5];
  logic [4:0] prev_en;
  bit         had_owner;

  initial begin
    rn    = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_r = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en",   32'(en_a),   32'h0);
    chk("rst_gid",  32'(gid_a),  32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_keep", 32'(keep_a), 32'h1);
    rn = 1'b1;
    step();

    // Single requester, DEAD=2
    req_a = 4'b0010;
    step();
    chk("t2_en",   32'(en_a),   32'h2);
    chk("t2_gid",  32'(gid_a),  32'h1);
    chk("t2_busy", 32'(busy_a), 32'h1);
    chk("t2_keep", 32'(keep_a), 32'h0);
    repeat (4) begin
      step();
      chk("t2_hold", 32'(en_a), 32'h2);
    end
    req_a = 4'b0000;
    step();
    chk("t2_rel_en",   32'(en_a),   32'h0);
    chk("t2_rel_busy", 32'(busy_a), 32'h0);
    chk("t2_rel_keep", 32'(keep_a), 32'h1);
    chk("t2_rel_gid",  32'(gid_a),  32'h1);
    step();
    chk("t2_turn_en", 32'(en_a), 32'h0);
    step();
    chk("t2_idle_en", 32'(en_a), 32'h0);
    chk("t2_idle_st", 32'(u_a.state_q), 32'(ST_IDLE));

    // Asynchronous reset in the middle of DRIVE
    req_a = 4'b0010;
    step();
    chk("t1_drive_en", 32'(en_a), 32'h2);
    #2 rn = 1'b0;
    #1;
    chk("t1_async_en",   32'(en_a),   32'h0);
    chk("t1_async_keep", 32'(keep_a), 32'h1);
    chk("t1_async_busy", 32'(busy_a), 32'h0);
    req_a = 4'b0000;
    rn    = 1'b1;
    step();
    chk("t1_post_st",  32'(u_a.state_q), 32'(ST_IDLE));
    chk("t1_post_gid", 32'(gid_a), 32'h0);
    req_a = 4'b1010;
    step();
    chk("t1_ptr_en",  32'(en_a),  32'h2);
    chk("t1_ptr_gid", 32'(gid_a), 32'h1);
    req_a = 4'b0000;

    // Fairness, MAXHOLD=4, DEAD=1
    req_b = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t3_gid", 32'(gid_b), 32'(k % 4));
      for (int c = 0; c < 4; c++) begin
        chk("t3_own", 32'(en_b), 32'd1 << (k % 4));
        if (c < 3) step();
      end
      step();
      chk("t3_gap", 32'(en_b), 32'h0);
      step();
    end
    req_b = 4'b0000;
    repeat (3) step();

    // Lone holder is never preempted
    req_b = 4'b0100;
    step();
    for (int k = 0; k < 40; k++) begin
      chk("t4_lone", 32'(en_b), 32'h4);
      step();
    end
    req_b = 4'b0000;

    // Request arriving during TURN, DEAD=3
    req_c = 4'b0001;
    step();
    chk("t5_own0", 32'(en_c), 32'h1);
    repeat (2) step();
    req_c = 4'b0000;
    step();
    chk("t5_fall", 32'(en_c), 32'h0);
    req_c = 4'b1000;
    step();
    chk("t5_gap2", 32'(en_c), 32'h0);
    step();
    chk("t5_gap3", 32'(en_c), 32'h0);
    step();
    chk("t5_own3", 32'(en_c), 32'h8);
    chk("t5_gid3", 32'(gid_c), 32'h3);

    // Random requests, N=5, DEAD=2, MAXHOLD=3: invariants every cycle
    zrun      = 0;
    prev_en   = '0;
    had_owner = 1'b0;
    for (int i = 0; i < 5; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(3) == 0) req_r = 5'($urandom);
      step();
      chk("t6_onehot0", 32'($onehot0(en_r)), 32'h1);
      chk("t6_keep",    32'(keep_r), 32'(~|en_r));
      chk("t6_busy",    32'(busy_r), 32'(|en_r));
      if (en_r != '0) begin
        if (prev_en != '0) chk("t6_stable", 32'(en_r), 32'(prev_en));
        else if (had_owner) chk("t6_gap", 32'(zrun >= 2), 32'h1);
        had_owner = 1'b1;
        zrun      = 0;
      end else begin
        zrun++;
      end
      prev_en = en_r;
      for (int i = 0; i < 5; i++) begin
        if (req_r[i] && !en_r[i]) waitc[i]++;
        else waitc[i] = 0;
        chk("t6_starve", 32'(waitc[i] <= 25), 32'h1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
